fft_conv_top: RTL and testbench
===============================

Name: fft_conv_top

Overview:
- Valid-mode 2-D convolution engine: convolves a 64x64 signed image with a 3x3 signed kernel and produces a 62x62 signed result map.
- Sits between three single-port word SRAMs: input (read-only), weight (read-only) and output (write).
- Started by a level `valid` from the host; signals completion on `Ready` once every output word is written.
- Computed exactly with direct multiply-accumulate, no FFT approximation. Result error is 0, well inside the system tolerance of ±3.

Parameters:
- IN_H, 64, input image rows
- IN_W, 64, input image columns
- K, 3, kernel size (K x K)
- DATA_W, 32, SRAM word width
- ADDR_W, 16, SRAM address width

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-high reset (asserted when 1), name kept per codebase
- valid  input  1  start request, level, held high by host until Ready rises
- Ready  output  1  done flag
- input_addr  output  16  input SRAM word address
- input_rdata  input  32  input SRAM read data, signed
- weight_addr  output  16  weight SRAM word address
- weight_rdata  input  32  weight SRAM read data, signed
- output_wen  output  1  output SRAM write enable, active high
- output_addr  output  16  output SRAM word address
- output_rdata  input  32  output SRAM read data, unused
- output_wdata  output  32  output SRAM write data, signed

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: Ready=0, output_wen=0, all addresses=0, output_wdata=0, FSM=IDLE, accumulator=0.
  - Reset asserted mid-operation aborts immediately to these values.
  - Output SRAM contents written so far are left as they are.
- Memory map:
  - input pixel (r,c) is at r*IN_W+c.
  - weight (kr,kc) is at kr*K+kc.
  - result (r,c) is at r*(IN_W-K+1)+c.
- SRAM timing: synchronous read, 1-cycle latency. An address driven in cycle N gives q valid in cycle N+1.
- SRAM writes: a write occurs at the rising edge where output_wen=1.
- Arithmetic:
  - out(r,c) = sum over kr,kc in 0..2 of in(r+kr,c+kc)*w(kr,kc), i.e. cross-correlation with no kernel flip.
  - Operands are the full 32-bit signed words.
  - Products and the accumulator are 32-bit two's complement, wrap on overflow.
- FSM states: IDLE -> LOAD_W -> CALC -> WRITE -> (CALC or DONE) -> IDLE.
  - IDLE: waits for valid=1. Sampled high, it clears the row/column counters and enters LOAD_W.
  - LOAD_W: reads weight words 0..8 into 9 internal registers, pipelined one read per cycle, 10 cycles.
  - CALC: reads the 9 window pixels for the current (r,c), pipelined, and accumulates them.
  - WRITE: drives output_wen=1 for exactly one cycle with output_addr=r*62+c and output_wdata=accumulator.
    - Then clears the accumulator and advances c; c wraps 61->0 with r incrementing.
    - After (61,61) the FSM goes to DONE; otherwise back to CALC.
- Write ordering: each of the 3844 results is written exactly once, in row-major order. No other output writes occur.
- DONE: Ready=1, held until valid is sampled low.
  - Then Ready=0 next cycle and FSM=IDLE.
  - A new run starts only on a later valid=1.
- Ready rises only after the final write has completed, never in the same cycle as output_wen=1.
- Control glitches: valid dropping before DONE is ignored; the run completes.
- Latency: about 10 + 3844*(9+2) cycles, under 43,000 cycles per frame. An exact count is not required, but must be deterministic.

Optional Feature:
- Macro: FFT_CONV_RELU_EN.
- Defined: output_wdata = accumulator if ≥0, else 0. This is applied at WRITE; timing and addresses are unchanged.
- Undefined (default): raw signed accumulator is written.

Test Plan:
- All input words=1, all weights=1, valid raised 2 cycles after reset release -> every output(r,c)=9; Ready rises once; exactly 3844 writes.
- Input(r,c)=r*64+c, weight(1,1)=1, other weights 0 -> output(r,c)=(r+1)*64+(c+1); check (0,0)=65 and (61,61)=4030.
- Input all =-128, weights all =127 -> every output=-146304. Tests signed multiply.
- Input(r,c)=c, weights row0={1,0,-1}, rows1-2 zero -> every output=-2. Tests window orientation.
- Reset asserted mid-CALC -> Ready=0 and output_wen=0 immediately. A fresh valid then completes with correct results.
- valid held low for 1000 cycles after reset -> no writes, Ready stays 0. Then valid=1 -> run completes. After valid=0, Ready drops within 1 cycle.

Source files
------------

// File: rtl/fft_conv_top.sv
// Direct 3x3 valid-mode convolution of a 64x64 image, SRAM-to-SRAM.
// Optional FFT_CONV_RELU_EN clamps negative results to zero at write time.
module fft_conv_top #(
  parameter int IN_H   = 64,
  parameter int IN_W   = 64,
  parameter int K      = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  output logic              Ready,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] input_rdata,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_rdata,
  output logic              output_wen,
  output logic [ADDR_W-1:0] output_addr,
  input  logic [DATA_W-1:0] output_rdata,
  output logic [DATA_W-1:0] output_wdata
);

  localparam int OUT_H = IN_H - K + 1;
  localparam int OUT_W = IN_W - K + 1;
  localparam int NT    = K * K;
  localparam int CW    = $clog2(NT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   w_q [NT];
  logic [ADDR_W-1:0]   r_q, c_q;
  logic                ready_q, wen_q;
  logic [ADDR_W-1:0]   iaddr_q, waddr_q, oaddr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [DATA_W-1:0]   prod, sum_d, wdata_d;
  logic [ADDR_W-1:0]   r_nx, c_nx;
  logic                last_px;
  logic                unused_rdata;

  assign unused_rdata = ^output_rdata;

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [ADDR_W-1:0] r,
    input logic [ADDR_W-1:0] c,
    input logic [CW-1:0]     t
  );
    logic [ADDR_W-1:0] kr, kc;
    kr = ADDR_W'(t / CW'(K));
    kc = ADDR_W'(t % CW'(K));
    return (r + kr) * ADDR_W'(IN_W) + c + kc;
  endfunction

  // Weights live in a rotating register file: tap t always sits in w_q[0].
  assign prod  = input_rdata * w_q[0];
  assign sum_d = acc_q + prod;

  always_comb begin
`ifdef FFT_CONV_RELU_EN
    wdata_d = sum_d[DATA_W-1] ? '0 : sum_d;
`else
    wdata_d = sum_d;
`endif
  end

  always_comb begin
    last_px = (r_q == ADDR_W'(OUT_H - 1)) && (c_q == ADDR_W'(OUT_W - 1));
    r_nx    = r_q;
    c_nx    = c_q + 1'b1;
    if (c_q == ADDR_W'(OUT_W - 1)) begin
      c_nx = '0;
      r_nx = r_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      iaddr_q <= '0;
      waddr_q <= '0;
      oaddr_q <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NT; i++) w_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid) begin
            r_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            waddr_q <= '0;
            state_q <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (cnt_q != '0) begin
            for (int i = 0; i < NT - 1; i++) w_q[i] <= w_q[i+1];
            w_q[NT-1] <= weight_rdata;
          end
          if (cnt_q == CW'(NT)) begin
            cnt_q   <= '0;
            iaddr_q <= pix_addr(r_q, c_q, '0);
            state_q <= S_CALC;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q < CW'(NT - 1))
              waddr_q <= ADDR_W'(cnt_q) + 1'b1;
          end
        end
        S_CALC: begin
          if (cnt_q != '0) begin
            acc_q <= sum_d;
            for (int i = 0; i < NT - 1; i++) w_q[i] <= w_q[i+1];
            w_q[NT-1] <= w_q[0];
          end
          if (cnt_q == CW'(NT)) begin
            cnt_q   <= '0;
            wen_q   <= 1'b1;
            oaddr_q <= r_q * ADDR_W'(OUT_W) + c_q;
            wdata_q <= wdata_d;
            state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q < CW'(NT - 1))
              iaddr_q <= pix_addr(r_q, c_q, cnt_q + 1'b1);
          end
        end
        S_WRITE: begin
          wen_q <= 1'b0;
          acc_q <= '0;
          if (last_px) begin
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            r_q     <= r_nx;
            c_q     <= c_nx;
            iaddr_q <= pix_addr(r_nx, c_nx, '0);
            state_q <= S_CALC;
          end
        end
        S_DONE: begin
          if (!valid) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ready        = ready_q;
  assign input_addr   = iaddr_q;
  assign weight_addr  = waddr_q;
  assign output_wen   = wen_q;
  assign output_addr  = oaddr_q;
  assign output_wdata = wdata_q;

endmodule

// File: tb/tb_fft_conv_top.sv
// Directed bench for fft_conv_top: partial runs aborted by reset,
// then one full frame with ordering, count and value checks.
module tb_fft_conv_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        Ready;
  logic [15:0] input_addr, weight_addr, output_addr;
  logic [31:0] input_rdata, weight_rdata, output_rdata, output_wdata;
  logic        output_wen;

  logic [31:0] in_mem  [0:4095];
  logic [31:0] w_mem   [0:15];
  logic [31:0] out_mem [0:3843];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int order_err = 0;
  int rises = 0;
  int overlap = 0;
  logic ready_prev = 1'b0;

  always #5 clk = ~clk;

  assign output_rdata = 32'h0;

  fft_conv_top dut (
    .clk          (clk),
    .rst_n        (rst),
    .valid        (valid),
    .Ready        (Ready),
    .input_addr   (input_addr),
    .input_rdata  (input_rdata),
    .weight_addr  (weight_addr),
    .weight_rdata (weight_rdata),
    .output_wen   (output_wen),
    .output_addr  (output_addr),
    .output_rdata (output_rdata),
    .output_wdata (output_wdata)
  );

  always @(posedge clk) begin
    input_rdata  <= in_mem[input_addr[11:0]];
    weight_rdata <= w_mem[weight_addr[3:0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      wr_cnt = 0;
      order_err = 0;
      rises = 0;
      overlap = 0;
      ready_prev = 1'b0;
    end else begin
      if (output_wen) begin
        if (int'(output_addr) != wr_cnt) order_err++;
        if (output_addr < 16'd3844) out_mem[output_addr] = output_wdata;
        wr_cnt++;
      end
      if (Ready && !ready_prev) rises++;
      if (Ready && output_wen) overlap++;
      ready_prev = Ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag,
             $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] expv(input int t, input int idx);
    int r, c;
    r = idx / 62;
    c = idx % 62;
    case (t)
      0:       return 32'd9;
      1:       return 32'((r + 1) * 64 + c + 1);
      2:       return -32'sd146304;
      default: return -32'sd2;
    endcase
  endfunction

  task automatic load(input int t);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        case (t)
          0:       in_mem[r*64+c] = 32'd1;
          1:       in_mem[r*64+c] = 32'(r * 64 + c);
          2:       in_mem[r*64+c] = -32'sd128;
          default: in_mem[r*64+c] = 32'(c);
        endcase
    for (int i = 0; i < 16; i++) w_mem[i] = 32'd0;
    case (t)
      0: for (int i = 0; i < 9; i++) w_mem[i] = 32'd1;
      1: w_mem[4] = 32'd1;
      2: for (int i = 0; i < 9; i++) w_mem[i] = 32'd127;
      default: begin
        w_mem[0] = 32'd1;
        w_mem[2] = -32'sd1;
      end
    endcase
  endtask

  function automatic int bad_words(input int t, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (out_mem[i] !== expv(t, i)) bad++;
    return bad;
  endfunction

  task automatic partial(input int t, input string tag);
    int k, n;
    load(t);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    valid = 1'b1;
    k = 0;
    while (wr_cnt < 120 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_progress"}, 32'(wr_cnt >= 120), 32'd1);
    k = 0;
    while (!output_wen && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    #1;
    n = wr_cnt;
    chk({tag, "_abort_ready"}, 32'(Ready), 32'd0);
    chk({tag, "_abort_wen"}, 32'(output_wen), 32'd0);
    chk({tag, "_abort_iaddr"}, 32'(input_addr), 32'd0);
    chk({tag, "_order"}, 32'(order_err), 32'd0);
    chk({tag, "_values"}, 32'(bad_words(t, n)), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 3844; i++) out_mem[i] = 32'hDEADBEEF;
    load(0);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_wen", 32'(output_wen), 32'd0);
    chk("rst_iaddr", 32'(input_addr), 32'd0);
    chk("rst_waddr", 32'(weight_addr), 32'd0);
    chk("rst_oaddr", 32'(output_addr), 32'd0);
    chk("rst_wdata", output_wdata, 32'd0);

    partial(0, "ones");
    partial(2, "signed");
    partial(3, "orient");

    load(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    chk("idle_writes", 32'(wr_cnt), 32'd0);
    chk("idle_rises", 32'(rises), 32'd0);
    chk("idle_ready", 32'(Ready), 32'd0);

    valid = 1'b1;
    k = 0;
    while (!Ready && k < 45000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_ready", 32'(Ready), 32'd1);
    chk("frame_writes", 32'(wr_cnt), 32'd3844);
    chk("frame_order", 32'(order_err), 32'd0);
    chk("frame_overlap", 32'(overlap), 32'd0);
    chk("frame_out00", out_mem[0], 32'd65);
    chk("frame_out6161", out_mem[3843], 32'd4030);
    chk("frame_values", 32'(bad_words(1, 3844)), 32'd0);
    repeat (5) @(negedge clk);
    chk("ready_held", 32'(Ready), 32'd1);
    valid = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(Ready), 32'd0);
    repeat (20) @(negedge clk);
    chk("post_writes", 32'(wr_cnt), 32'd3844);
    chk("post_rises", 32'(rises), 32'd1);
    chk("post_ready", 32'(Ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
